// File: rtl/apb_requester.sv
// apb_requester: turns single commands from a valid/ready port into APB
// transfers. Each transfer goes through SETUP and ACCESS. The result is held
// in RESP until it is consumed. A bounded wait counter ends stalled transfers
// with a timeout error.
module apb_requester #(
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk,
  input  logic                  preset,
  // command port
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_wdata,
  input  logic [3:0]            cmd_strb,
  // response port
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  // APB requester side
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [31:0]           pwdata,
  output logic [3:0]            pstrb,
  input  logic                  pready,
  input  logic [31:0]           prdata,
  input  logic                  pslverr
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  // last wait count allowed before the transfer is abandoned
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]            state_q, state_d;
  logic [7:0]            wait_q, wait_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [31:0]           pwdata_q, pwdata_d;
  logic [3:0]            pstrb_q, pstrb_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  tmo_q, tmo_d;

  // handshake and APB control lines are decoded from the state alone
  always_comb begin
    cmd_ready = (state_q == IDLE);
    psel      = (state_q == SETUP) || (state_q == ACCESS);
    penable   = (state_q == ACCESS);
    rsp_valid = (state_q == RESP);
  end

  assign paddr       = paddr_q;
  assign pwrite      = pwrite_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = tmo_q;

  // next-state logic: command capture, APB phase sequencing, completion and timeout
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d  = SETUP;
          wait_d   = 8'd0;
          paddr_d  = cmd_addr;
          pwrite_d = cmd_write;
          // reads never drive data or strobes onto the bus
          pwdata_d = cmd_write ? cmd_wdata : 32'd0;
          pstrb_d  = cmd_write ? cmd_strb : 4'd0;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          state_d = RESP;
          rdata_d = pwrite_q ? 32'd0 : prdata;
          err_d   = pslverr;
          tmo_d   = 1'b0;
        end else if (wait_q == WAIT_LAST) begin
          state_d = RESP;
          rdata_d = 32'd0;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state and datapath registers; reset abandons any transfer in flight
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q  <= IDLE;
      wait_q   <= 8'd0;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= 32'd0;
      pstrb_q  <= 4'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
    end
  end

endmodule

// File: tb/tb_apb_requester.sv
// tb_apb_requester: directed self-checking bench for apb_requester.
// Inputs change 1 ns after each rising edge, and outputs are checked at that point.
module tb_apb_requester;

  localparam int AW = 10;

  logic          pclk = 1'b0;
  logic          preset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [31:0]   cmd_wdata = 32'd0;
  logic [3:0]    cmd_strb = 4'd0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic [AW-1:0] paddr;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [31:0]   pwdata;
  logic [3:0]    pstrb;
  logic          pready = 1'b0;
  logic [31:0]   prdata = 32'd0;
  logic          pslverr = 1'b0;

  int checkCount = 0;
  int errorCount = 0;

  apb_requester #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata),
    .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  // single comparison point: count it, report it if it differs
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // present a command on the command port
  task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr,
                               input logic [31:0] wdata, input logic [3:0] strb);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_strb  = strb;
  endtask

  int accessCount;

  initial begin
    // reset values while reset is held
    #12;
    checkOutput("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("rst_psel", {31'd0, psel}, 32'd0);
    checkOutput("rst_penable", {31'd0, penable}, 32'd0);
    checkOutput("rst_pwrite", {31'd0, pwrite}, 32'd0);
    checkOutput("rst_paddr", {22'd0, paddr}, 32'd0);
    checkOutput("rst_pwdata", pwdata, 32'd0);
    checkOutput("rst_pstrb", {28'd0, pstrb}, 32'd0);
    checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    checkOutput("rst_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
    tick();
    preset = 1'b0;

    // zero-wait write, accepted at the first edge after release
    pready = 1'b1;
    applyStimulus(1'b1, 10'd5, 32'hA5A5_1234, 4'b0011);
    tick();
    cmd_valid = 1'b0;
    checkOutput("w_setup_psel", {31'd0, psel}, 32'd1);
    checkOutput("w_setup_penable", {31'd0, penable}, 32'd0);
    checkOutput("w_setup_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    checkOutput("w_setup_paddr", {22'd0, paddr}, 32'd5);
    checkOutput("w_setup_pwrite", {31'd0, pwrite}, 32'd1);
    checkOutput("w_setup_pwdata", pwdata, 32'hA5A5_1234);
    checkOutput("w_setup_pstrb", {28'd0, pstrb}, 32'h3);
    tick();
    checkOutput("w_access_psel", {31'd0, psel}, 32'd1);
    checkOutput("w_access_penable", {31'd0, penable}, 32'd1);
    checkOutput("w_access_pstrb", {28'd0, pstrb}, 32'h3);
    checkOutput("w_access_pwdata", pwdata, 32'hA5A5_1234);
    tick();
    checkOutput("w_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    checkOutput("w_rsp_psel", {31'd0, psel}, 32'd0);
    checkOutput("w_rsp_err", {31'd0, rsp_err}, 32'd0);
    checkOutput("w_rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("w_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
    tick();
    checkOutput("w_idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("w_idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);

    // read with three wait states; pready high during SETUP must be ignored
    prdata = 32'hDEAD_BEEF;
    applyStimulus(1'b0, 10'd7, 32'hFFFF_FFFF, 4'hF);
    tick();
    cmd_valid = 1'b0;
    checkOutput("r_setup_pstrb", {28'd0, pstrb}, 32'd0);
    checkOutput("r_setup_pwdata", pwdata, 32'd0);
    checkOutput("r_setup_pwrite", {31'd0, pwrite}, 32'd0);
    checkOutput("r_setup_paddr", {22'd0, paddr}, 32'd7);
    tick();
    pready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("r_penable_%0d", i), {31'd0, penable}, 32'd1);
      checkOutput($sformatf("r_paddr_%0d", i), {22'd0, paddr}, 32'd7);
      if (i == 3) begin
        pready = 1'b1;
        prdata = 32'h0000_00C3;
      end
      tick();
    end
    checkOutput("r_rsp_psel", {31'd0, psel}, 32'd0);
    checkOutput("r_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    checkOutput("r_rsp_rdata", rsp_rdata, 32'h0000_00C3);
    checkOutput("r_rsp_err", {31'd0, rsp_err}, 32'd0);
    tick();

    // read answered with pslverr, then a response held back for 5 cycles
    prdata  = 32'd0;
    pslverr = 1'b1;
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 10'd1, 32'd0, 4'd0);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    pslverr = 1'b0;
    applyStimulus(1'b1, 10'd9, 32'h0000_5555, 4'b1000);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("e_rsp_valid_%0d", i), {31'd0, rsp_valid}, 32'd1);
      checkOutput($sformatf("e_rsp_err_%0d", i), {31'd0, rsp_err}, 32'd1);
      checkOutput($sformatf("e_rsp_timeout_%0d", i), {31'd0, rsp_timeout}, 32'd0);
      checkOutput($sformatf("e_rsp_rdata_%0d", i), rsp_rdata, 32'd0);
      checkOutput($sformatf("e_cmd_ready_%0d", i), {31'd0, cmd_ready}, 32'd0);
      checkOutput($sformatf("e_psel_%0d", i), {31'd0, psel}, 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    checkOutput("e_after_hs_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("e_after_hs_psel", {31'd0, psel}, 32'd0);
    tick();
    cmd_valid = 1'b0;
    checkOutput("n_setup_psel", {31'd0, psel}, 32'd1);
    checkOutput("n_setup_paddr", {22'd0, paddr}, 32'd9);
    checkOutput("n_setup_pstrb", {28'd0, pstrb}, 32'h8);
    tick();
    tick();
    checkOutput("n_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    checkOutput("n_rsp_err", {31'd0, rsp_err}, 32'd0);
    tick();

    // timeout: pready never rises, expect exactly 16 ACCESS cycles
    pready = 1'b0;
    prdata = 32'hFFFF_0000;
    applyStimulus(1'b0, 10'd3, 32'd0, 4'd0);
    tick();
    cmd_valid = 1'b0;
    tick();
    accessCount = 0;
    for (int i = 0; i < 40; i++) begin
      if (!(psel && penable)) break;
      accessCount++;
      tick();
    end
    checkOutput("t_access_cycles", accessCount, 32'd16);
    checkOutput("t_psel", {31'd0, psel}, 32'd0);
    checkOutput("t_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    checkOutput("t_rsp_err", {31'd0, rsp_err}, 32'd1);
    checkOutput("t_rsp_timeout", {31'd0, rsp_timeout}, 32'd1);
    checkOutput("t_rsp_rdata", rsp_rdata, 32'd0);
    tick();

    // reset pulsed in the middle of a stalled ACCESS
    applyStimulus(1'b1, 10'd2, 32'h1234_5678, 4'hF);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    checkOutput("x_pre_penable", {31'd0, penable}, 32'd1);
    preset = 1'b1;
    #1;
    checkOutput("x_async_psel", {31'd0, psel}, 32'd0);
    checkOutput("x_async_penable", {31'd0, penable}, 32'd0);
    checkOutput("x_async_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    preset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("x_no_rsp_%0d", i), {31'd0, rsp_valid}, 32'd0);
    end
    pready = 1'b1;
    applyStimulus(1'b1, 10'h3FF, 32'h0000_0011, 4'hF);
    tick();
    cmd_valid = 1'b0;
    checkOutput("x_setup_paddr", {22'd0, paddr}, 32'h3FF);
    checkOutput("x_setup_pwdata", pwdata, 32'h0000_0011);
    tick();
    tick();
    checkOutput("x_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    checkOutput("x_rsp_err", {31'd0, rsp_err}, 32'd0);
    checkOutput("x_rsp_rdata", rsp_rdata, 32'd0);
    tick();
    checkOutput("x_idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
